// File: rtl/apb4_slave_mem_pkg.sv
// Shared types and helpers for the parametrised APB4 memory slave.
package apb4_slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // Number of byte-offset bits below the word index in paddr.
    function automatic int word_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb4_slave_mem_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous byte-enable write, asynchronous read.
module apb4_slave_mem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Byte-lane write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we && wstrb[i]) begin
                mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 memory slave with wait states, byte strobes and range error response.
// Optional APB4_SLAVE_MEM_PROT_EN adds pprot and rejects unprivileged writes.
module apb4_slave_mem
    import apb4_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`ifdef APB4_SLAVE_MEM_PROT_EN
    input  logic [2:0]              pprot,
`endif
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int LSB    = word_lsb(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [IDX_W:0] DEPTH_L  = (IDX_W + 1)'(DEPTH);
    localparam logic [3:0]     CNT_INIT = 4'(WAIT_STATES - 1);

    state_e                 state_r;
    logic [3:0]             cnt_r;
    logic                   wr_r;
    logic                   err_r;
    logic [RAM_AW-1:0]      idx_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic [STRB_W-1:0]      strb_r;

    logic [IDX_W-1:0]       setup_idx_s;
    logic                   range_err_s;
    logic                   setup_err_s;
    logic                   setup_s;
    logic [RAM_AW-1:0]      ram_raddr_s;
    logic [DATA_WIDTH-1:0]  ram_rdata_s;
    logic                   ram_we_s;
    logic                   unused_ok_s;

    assign setup_s     = psel && !penable;
    assign setup_idx_s = paddr[ADDR_WIDTH-1:LSB];
    assign range_err_s = ({1'b0, setup_idx_s} >= DEPTH_L);

`ifdef APB4_SLAVE_MEM_PROT_EN
    assign setup_err_s = range_err_s || (pwrite && !pprot[0]);
    assign unused_ok_s = ^{1'b0, paddr, pprot};
`else
    assign setup_err_s = range_err_s;
    assign unused_ok_s = ^{1'b0, paddr};
`endif

    // Zero-wait reads come straight from the bus address; otherwise use the latched index.
    always_comb begin
        ram_raddr_s = idx_r;
        if (state_r == IDLE) begin
            ram_raddr_s = setup_idx_s[RAM_AW-1:0];
        end else begin
            ram_raddr_s = idx_r;
        end
    end

    assign ram_we_s = (state_r == ACCESS) && wr_r && !err_r;

    apb4_slave_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (idx_r),
        .wdata (wdata_r),
        .wstrb (strb_r),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Transfer FSM with registered bus response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            wr_r    <= 1'b0;
            err_r   <= RESP_OKAY;
            idx_r   <= {RAM_AW{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            strb_r  <= {STRB_W{1'b0}};
            pready  <= 1'b0;
            pslverr <= RESP_OKAY;
            prdata  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (setup_s) begin
                        wr_r    <= pwrite;
                        err_r   <= setup_err_s;
                        idx_r   <= setup_idx_s[RAM_AW-1:0];
                        wdata_r <= pwdata;
                        strb_r  <= pstrb;
                        if (WAIT_STATES == 0) begin
                            state_r <= ACCESS;
                            pready  <= 1'b1;
                            pslverr <= setup_err_s;
                            prdata  <= (!pwrite && !setup_err_s) ? ram_rdata_s
                                                                  : {DATA_WIDTH{1'b0}};
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    // Dropping psel mid-wait abandons the transfer without touching memory.
                    if (!psel) begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= ACCESS;
                        pready  <= 1'b1;
                        pslverr <= err_r;
                        prdata  <= (!wr_r && !err_r) ? ram_rdata_s : {DATA_WIDTH{1'b0}};
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ACCESS: begin
                    state_r <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= RESP_OKAY;
                    prdata  <= {DATA_WIDTH{1'b0}};
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    pready  <= 1'b0;
                    pslverr <= RESP_OKAY;
                    prdata  <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Directed scoreboard bench: one zero-wait and one three-wait instance on a shared bus.
module tb_apb4_slave_mem;
    import apb4_slave_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        psel0;
    logic        psel3;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
`ifdef APB4_SLAVE_MEM_PROT_EN
    logic [2:0]  pprot;
`endif
    logic [31:0] prdata0;
    logic        pready0;
    logic        pslverr0;
    logic [31:0] prdata3;
    logic        pready3;
    logic        pslverr3;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    apb4_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
`ifdef APB4_SLAVE_MEM_PROT_EN
        .pprot(pprot),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb4_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
`ifdef APB4_SLAVE_MEM_PROT_EN
        .pprot(pprot),
`endif
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transfer; expected response is queued at drive time and popped at pready.
    task automatic xfer(input bit ws3, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e,
                        input string tag);
        exp_t e;
        int   waits;
        bit   seen;
        sb_q.push_back('{exp_d, exp_e, ws3 ? 3 : 0});
        psel0 = !ws3; psel3 = ws3; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ws3 ? pready3 : pready0) seen = 1'b1;
            else waits++;
        end
        e = sb_q.pop_front();
        chk({tag, "_ready"}, 32'(seen), 32'd1);
        chk({tag, "_wait"}, 32'(waits), 32'(e.waits));
        chk({tag, "_err"}, 32'(ws3 ? pslverr3 : pslverr0), 32'(e.err));
        chk({tag, "_data"}, ws3 ? prdata3 : prdata0, e.data);
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // Start a transfer on the wait-state instance and hold it for n access-phase edges.
    task automatic start_hold3(input bit wr, input logic [9:0] a, input logic [31:0] d, input int n);
        psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 10'd0; pwdata = 32'd0; pstrb = 4'h0;
`ifdef APB4_SLAVE_MEM_PROT_EN
        pprot = 3'b001;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready0", 32'(pready0), 32'd0);
        chk("rst_pslverr0", 32'(pslverr0), 32'd0);
        chk("rst_prdata0", prdata0, 32'd0);
        chk("rst_pready3", 32'(pready3), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "w_10");
        xfer(1'b0, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "r_10");

        xfer(1'b0, 1'b1, 10'h004, 32'h11223344, 4'hF, 32'h0, 1'b0, "w_04");
        xfer(1'b0, 1'b1, 10'h004, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, "w_04_strb");
        xfer(1'b0, 1'b0, 10'h004, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "r_04");

        xfer(1'b0, 1'b1, 10'h010, 32'h00000000, 4'h0, 32'h0, 1'b0, "w_10_nostrb");
        xfer(1'b0, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "r_10_keep");

        xfer(1'b1, 1'b1, 10'h020, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "w3_20");
        xfer(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "r3_20");

        xfer(1'b0, 1'b1, 10'h000, 32'h5A5A0001, 4'hF, 32'h0, 1'b0, "w_00");
        xfer(1'b0, 1'b1, 10'h0FC, 32'h600DF00D, 4'hF, 32'h0, 1'b0, "w_last");
        xfer(1'b0, 1'b0, 10'h0FC, 32'h0, 4'h0, 32'h600DF00D, 1'b0, "r_last");
        xfer(1'b0, 1'b1, 10'h100, 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1, "w_oor");
        xfer(1'b0, 1'b0, 10'h100, 32'h0, 4'h0, 32'h0, 1'b1, "r_oor");
        xfer(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 32'h5A5A0001, 1'b0, "r_00_alias");

        // Reset while a read sits in its access phase with data on the bus.
        start_hold3(1'b0, 10'h020, 32'h0, 3);
        chk("mid_pready", 32'(pready3), 32'd1);
        chk("mid_prdata", prdata3, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        chk("rstmid_pready", 32'(pready3), 32'd0);
        chk("rstmid_pslverr", 32'(pslverr3), 32'd0);
        chk("rstmid_prdata", prdata3, 32'd0);
        chk("rstmid_state", 32'(u_dut3.state_r), 32'(IDLE));
        psel3 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while a write is in its access phase drops the write.
        xfer(1'b1, 1'b1, 10'h014, 32'h01234567, 4'hF, 32'h0, 1'b0, "w3_14");
        start_hold3(1'b1, 10'h014, 32'hFFFFFFFF, 3);
        rst = 1'b1;
        #1;
        psel3 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 10'h014, 32'h0, 4'h0, 32'h01234567, 1'b0, "r3_14_kept");

        // Abort by dropping psel during wait states.
        xfer(1'b1, 1'b1, 10'h024, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0, "w3_24");
        start_hold3(1'b1, 10'h024, 32'h77777777, 1);
        psel3 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_state", 32'(u_dut3.state_r), 32'(IDLE));
        chk("abort_pready", 32'(pready3), 32'd0);
        xfer(1'b1, 1'b0, 10'h024, 32'h0, 4'h0, 32'h0BADC0DE, 1'b0, "r3_24_kept");

`ifdef APB4_SLAVE_MEM_PROT_EN
        xfer(1'b0, 1'b1, 10'h008, 32'h13579BDF, 4'hF, 32'h0, 1'b0, "w_08");
        pprot = 3'b000;
        xfer(1'b0, 1'b1, 10'h008, 32'hFFFF0000, 4'hF, 32'h0, 1'b1, "w_08_unpriv");
        xfer(1'b0, 1'b0, 10'h008, 32'h0, 4'h0, 32'h13579BDF, 1'b0, "r_08_unpriv");
        pprot = 3'b001;
        xfer(1'b0, 1'b1, 10'h008, 32'h2468ACE0, 4'hF, 32'h0, 1'b0, "w_08_priv");
        xfer(1'b0, 1'b0, 10'h008, 32'h0, 4'h0, 32'h2468ACE0, 1'b0, "r_08_priv");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
